trace_uart_streamer: RTL and testbench

Frame serialiser between the capture buffers and `uart_tx`. Once per measurement, after AES and sensor capture finish, it sends one framed trace over the UART byte interface: a sync word, plaintext, key, ciphertext, the sensor sample buffer read from RAM, and an XOR checksum. It then holds an inter-frame gap before accepting the next start.

---
 rtl/trace_pkg.sv | 27 ++
 rtl/trace_byte_mux.sv | 44 ++++
 rtl/trace_uart_streamer.sv | 162 ++++++++++++++++
 tb/tb_trace_uart_streamer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared constants, frame layout and FSM state type for the trace frame serialiser.
package trace_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  localparam int unsigned PT_OFS  = 2;
  localparam int unsigned KEY_OFS = 18;
  localparam int unsigned CT_OFS  = 34;
  localparam int unsigned SMP_OFS = 50;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StWait,
    StGap
  } state_e;

  // Byte k of a 128-bit word, MSB byte first (k = 0 selects bits 127:120).
  function automatic logic [7:0] word_byte(input logic [127:0] w, input logic [3:0] k);
    logic [6:0] base;
    base = {~k, 3'b000};
    return w[base +: 8];
  endfunction

endpackage

// File: rtl/trace_byte_mux.sv
// Selects the frame byte for a given index: sync, pt, key, ct, sample or checksum.
module trace_byte_mux
  import trace_pkg::*;
#(
  parameter int unsigned SAMPLES = 2048,
  parameter int unsigned IDX_W   = 12
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [127:0]     pt_i,
  input  logic [127:0]     key_i,
  input  logic [127:0]     ct_i,
  input  logic [7:0]       smp_data_i,
  input  logic [7:0]       csum_i,
  output logic [7:0]       byte_o
);

  localparam logic [IDX_W-1:0] KeyLo = IDX_W'(KEY_OFS);
  localparam logic [IDX_W-1:0] CtLo  = IDX_W'(CT_OFS);
  localparam logic [IDX_W-1:0] SmpLo = IDX_W'(SMP_OFS);
  localparam logic [IDX_W-1:0] SmpHi = IDX_W'(SMP_OFS + SAMPLES);

  // The three 16-byte fields start 16 apart, so one offset yields the byte lane for all.
  logic [3:0] lane;
  assign lane = 4'(idx_i - IDX_W'(PT_OFS));

  always_comb begin
    if (idx_i == '0) begin
      byte_o = SYNC0;
    end else if (idx_i == IDX_W'(1)) begin
      byte_o = SYNC1;
    end else if (idx_i < KeyLo) begin
      byte_o = word_byte(pt_i, lane);
    end else if (idx_i < CtLo) begin
      byte_o = word_byte(key_i, lane);
    end else if (idx_i < SmpLo) begin
      byte_o = word_byte(ct_i, lane);
    end else if (idx_i < SmpHi) begin
      byte_o = smp_data_i;
    end else begin
      byte_o = csum_i;
    end
  end

endmodule

// File: rtl/trace_uart_streamer.sv
// Serialises one trace frame (sync, pt, key, ct, samples, XOR checksum) to uart_tx per start.
module trace_uart_streamer
  import trace_pkg::*;
#(
  parameter int unsigned SAMPLES    = 2048,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned GAP_CYCLES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [127:0]      pt_i,
  input  logic [127:0]      key_i,
  input  logic [127:0]      ct_i,
  output logic [ADDR_W-1:0] smp_addr_o,
  input  logic [7:0]        smp_data_i,
  output logic              tx_dv_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int unsigned NBytes = SAMPLES + 51;
  localparam int unsigned IdxW   = $clog2(NBytes);
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);
  localparam logic [IdxW-1:0] CsumLo  = IdxW'(PT_OFS);
  localparam logic [IdxW-1:0] SmpLo   = IdxW'(SMP_OFS);
  localparam logic [IdxW-1:0] SmpHi   = IdxW'(SMP_OFS + SAMPLES);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d, idx_nxt;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
  logic [127:0]      pt_q, pt_d, key_q, key_d, ct_q, ct_d;
  logic [7:0]        csum_q, csum_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        mux_byte;

  trace_byte_mux #(
    .SAMPLES(SAMPLES),
    .IDX_W  (IdxW)
  ) u_byte_mux (
    .idx_i     (idx_q),
    .pt_i      (pt_q),
    .key_i     (key_q),
    .ct_i      (ct_q),
    .smp_data_i(smp_data_i),
    .csum_i    (csum_q),
    .byte_o    (mux_byte)
  );

  assign idx_nxt = idx_q + IdxW'(1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    smp_addr_d   = smp_addr_q;
    pt_d         = pt_q;
    key_d        = key_q;
    ct_d         = ct_q;
    csum_d       = csum_q;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    gap_d        = gap_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pt_d       = pt_i;
          key_d      = key_i;
          ct_d       = ct_i;
          idx_d      = '0;
          smp_addr_d = '0;
          csum_d     = '0;
          busy_d     = 1'b1;
          state_d    = StFetch;
        end
      end
      StFetch: state_d = StSend;
      StSend: begin
        tx_byte_d = mux_byte;
        tx_dv_d   = 1'b1;
        if (idx_q >= CsumLo && idx_q < SmpHi) csum_d = csum_q ^ mux_byte;
        state_d = StWait;
      end
      StWait: begin
        // A done pulse coincident with our own strobe belongs to the previous byte.
        if (tx_done_i && !tx_dv_q) begin
          if (idx_q == LastIdx) begin
            if (GAP_CYCLES == 0) begin
              frame_done_d = 1'b1;
              busy_d       = 1'b0;
              state_d      = StIdle;
            end else begin
              gap_d   = '0;
              state_d = StGap;
            end
          end else begin
            idx_d = idx_nxt;
            if (idx_nxt >= SmpLo && idx_nxt < SmpHi) smp_addr_d = ADDR_W'(idx_nxt - SmpLo);
            state_d = StFetch;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      smp_addr_q   <= '0;
      pt_q         <= '0;
      key_q        <= '0;
      ct_q         <= '0;
      csum_q       <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= '0;
      gap_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      smp_addr_q   <= smp_addr_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      ct_q         <= ct_d;
      csum_q       <= csum_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      gap_q        <= gap_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign smp_addr_o   = smp_addr_q;
  assign tx_dv_o      = tx_dv_q;
  assign tx_byte_o    = tx_byte_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_trace_uart_streamer.sv
// Scoreboard bench: a full-size DUT (2048 samples, 4096 gap) and a tiny one (4 samples, no gap).
module tb_trace_uart_streamer;

  localparam int unsigned SampA = 2048;
  localparam int unsigned GapA  = 4096;
  localparam int unsigned SampB = 4;
  localparam int unsigned GapB  = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        start;
  logic [1:0][127:0] pt, key, ct;
  logic [1:0][7:0]   smp_data;
  logic [1:0]        tx_done = '0;
  wire  [10:0]       smp_addr_a;
  wire  [1:0]        smp_addr_b;
  wire  [1:0]        tx_dv, busy, frame_done;
  wire  [1:0][7:0]   tx_byte;

  logic [7:0] ram [2][2048];

  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q [2][$];
  int unsigned fd_q  [2][$];
  int unsigned sent      [2] = '{0, 0};
  int unsigned fd_seen   [2] = '{0, 0};
  int unsigned uart_cnt  [2] = '{0, 0};
  int unsigned hold_next [2] = '{0, 0};
  bit          spur_next [2] = '{1'b0, 1'b0};
  bit          uart_last [2] = '{1'b0, 1'b0};

  trace_uart_streamer #(.SAMPLES(SampA), .ADDR_W(11), .GAP_CYCLES(GapA)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .pt_i(pt[0]), .key_i(key[0]), .ct_i(ct[0]),
    .smp_addr_o(smp_addr_a), .smp_data_i(smp_data[0]), .tx_dv_o(tx_dv[0]),
    .tx_byte_o(tx_byte[0]), .tx_done_i(tx_done[0]), .busy_o(busy[0]),
    .frame_done_o(frame_done[0])
  );

  trace_uart_streamer #(.SAMPLES(SampB), .ADDR_W(2), .GAP_CYCLES(GapB)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .pt_i(pt[1]), .key_i(key[1]), .ct_i(ct[1]),
    .smp_addr_o(smp_addr_b), .smp_data_i(smp_data[1]), .tx_dv_o(tx_dv[1]),
    .tx_byte_o(tx_byte[1]), .tx_done_i(tx_done[1]), .busy_o(busy[1]),
    .frame_done_o(frame_done[1])
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    smp_data[0] <= ram[0][smp_addr_a];
    smp_data[1] <= ram[1][{9'd0, smp_addr_b}];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference frame: layout and checksum built straight from the frame definition.
  task automatic push_frame(input int d, input logic [127:0] p, k, c);
    logic [7:0]   cs, b;
    logic [127:0] flds [3];
    int unsigned  ns;
    cs = 8'h00;
    flds[0] = p;
    flds[1] = k;
    flds[2] = c;
    ns = (d == 0) ? SampA : SampB;
    exp_q[d].push_back(8'hA5);
    exp_q[d].push_back(8'h5A);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        b = flds[f][127-8*i -: 8];
        exp_q[d].push_back(b);
        cs ^= b;
      end
    end
    for (int a = 0; a < int'(ns); a++) begin
      b = ram[d][a];
      exp_q[d].push_back(b);
      cs ^= b;
    end
    exp_q[d].push_back(cs);
  endtask

  // Monitor + UART model: pops expected bytes on tx_dv and answers with tx_done later.
  always @(negedge clk) begin
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      tx_done[d] = 1'b0;
      if (rst) begin
        exp_q[d].delete();
        fd_q[d].delete();
        uart_last[d] = 1'b0;
      end
      if (tx_dv[d]) begin
        sent[d]++;
        chk($sformatf("dut%0d tx_dv while byte outstanding", d), 32'(uart_cnt[d] == 0), 1);
        chk($sformatf("dut%0d busy during byte", d), 32'(busy[d]), 1);
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected tx_dv: got byte %0h want no byte", d, tx_byte[d]);
        end else begin
          e = exp_q[d].pop_front();
          chk($sformatf("dut%0d byte %0d", d, sent[d] - 1), 32'(tx_byte[d]), 32'(e));
          if (exp_q[d].size() == 0) uart_last[d] = 1'b1;
        end
      end
      if (frame_done[d]) begin
        fd_seen[d]++;
        if (fd_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected frame_done: got pulse at %0d want none", d, cyc);
        end else begin
          chk($sformatf("dut%0d frame_done cycle", d), cyc, fd_q[d].pop_front());
        end
        chk($sformatf("dut%0d busy at frame_done", d), 32'(busy[d]), 0);
      end
      if (uart_cnt[d] != 0) begin
        uart_cnt[d]--;
        if (uart_cnt[d] == 0) begin
          tx_done[d] = 1'b1;
          if (uart_last[d]) begin
            fd_q[d].push_back(cyc + 1 + ((d == 0) ? GapA : GapB));
            uart_last[d] = 1'b0;
          end
        end
      end
      if (tx_dv[d]) begin
        uart_cnt[d]  = (hold_next[d] != 0) ? hold_next[d] : $urandom_range(6, 1);
        hold_next[d] = 0;
        if (spur_next[d]) begin
          tx_done[d]   = 1'b1;
          spur_next[d] = 1'b0;
        end
      end
    end
  end

  task automatic check_reset(input int d);
    chk($sformatf("dut%0d reset tx_dv", d), 32'(tx_dv[d]), 0);
    chk($sformatf("dut%0d reset tx_byte", d), 32'(tx_byte[d]), 0);
    chk($sformatf("dut%0d reset smp_addr", d), (d == 0) ? 32'(smp_addr_a) : 32'(smp_addr_b), 0);
    chk($sformatf("dut%0d reset busy", d), 32'(busy[d]), 0);
    chk($sformatf("dut%0d reset frame_done", d), 32'(frame_done[d]), 0);
  endtask

  task automatic send_frame(input int d, input logic [127:0] p, k, c);
    push_frame(d, p, k, c);
    @(posedge clk); #1;
    start[d] = 1'b1; pt[d] = p; key[d] = k; ct[d] = c;
    @(posedge clk); #1;
    start[d] = 1'b0; pt[d] = rand128(); key[d] = rand128(); ct[d] = rand128();
    @(negedge clk);
    chk($sformatf("dut%0d busy after start", d), 32'(busy[d]), 1);
    chk($sformatf("dut%0d tx_dv at E+1", d), 32'(tx_dv[d]), 0);
    @(negedge clk);
    chk($sformatf("dut%0d tx_dv at E+2", d), 32'(tx_dv[d]), 0);
    @(negedge clk);
    chk($sformatf("dut%0d first tx_dv after E+2", d), 32'(tx_dv[d]), 1);
  endtask

  task automatic pulse_start(input int d);
    @(posedge clk); #1;
    start[d] = 1'b1; pt[d] = rand128();
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_sent(input int d, input int unsigned n);
    int unsigned t = 0;
    while (sent[d] < n && t < 60000) begin
      @(negedge clk); #1;
      t++;
    end
    chk($sformatf("dut%0d reached byte count %0d", d, n), 32'(sent[d] >= n), 1);
  endtask

  task automatic wait_fd(input int d, input int unsigned target);
    int unsigned t = 0;
    while (fd_seen[d] < target && t < 60000) begin
      @(negedge clk); #1;
      t++;
    end
    chk($sformatf("dut%0d frame_done seen", d), 32'(fd_seen[d] >= target), 1);
    chk($sformatf("dut%0d all expected bytes sent", d), 32'(exp_q[d].size()), 0);
  endtask

  initial begin
    int unsigned base, f, tgt, t;
    rst = 1'b1; start = '0; pt = '0; key = '0; ct = '0;
    for (int a = 0; a < 2048; a++) begin
      ram[0][a] = 8'(a);
      ram[1][a] = 8'h00;
    end
    ram[1][0] = 8'h01; ram[1][1] = 8'h02; ram[1][2] = 8'h04; ram[1][3] = 8'h08;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    @(posedge clk); #1 rst = 1'b0;

    // Small DUT: directed frame, then randomised ones.
    f = fd_seen[1];
    send_frame(1, '0, '0, '0);
    wait_fd(1, f + 1);
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 4; a++) ram[1][a] = 8'($urandom);
      f = fd_seen[1];
      send_frame(1, rand128(), rand128(), rand128());
      wait_fd(1, f + 1);
    end

    // Full frame with ignored start pulses at bytes 0, 60, 2098 and in the frame_done cycle.
    base = sent[0];
    f = fd_seen[0];
    send_frame(0, 128'h000102030405060708090A0B0C0D0E0F, {16{8'h11}}, {8'h80, 120'h0});
    wait_sent(0, base + 1);
    pulse_start(0);
    wait_sent(0, base + 61);
    pulse_start(0);
    wait_sent(0, base + 2099);
    pulse_start(0);
    t = 0;
    while (fd_q[0].size() == 0 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    chk("dut0 frame_done scheduled", 32'(fd_q[0].size()), 1);
    if (fd_q[0].size() != 0) begin
      tgt = fd_q[0][0];
      t = 0;
      while (cyc != tgt - 1 && t < 10000) begin
        @(posedge clk); #1;
        t++;
      end
      start[0] = 1'b1; pt[0] = rand128();
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    wait_fd(0, f + 1);
    repeat (40) @(negedge clk);
    #1;
    chk("dut0 single frame length", sent[0] - base, 2099);
    chk("dut0 idle after ignored start", 32'(busy[0]), 0);

    // Reset while byte 100 is in flight; its late tx_done must be ignored.
    for (int a = 0; a < 2048; a++) ram[0][a] = 8'($urandom);
    base = sent[0];
    send_frame(0, rand128(), rand128(), rand128());
    wait_sent(0, base + 100);
    hold_next[0] = 12;
    wait_sent(0, base + 101);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset(0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("dut0 no tx_dv after reset", sent[0] - base, 101);
    chk("dut0 idle after reset", 32'(busy[0]), 0);

    // New frame after reset, with a 1000-cycle tx_done hold-off and a spurious tx_done.
    base = sent[0];
    f = fd_seen[0];
    send_frame(0, rand128(), rand128(), rand128());
    wait_sent(0, base + 5);
    hold_next[0] = 1000;
    wait_sent(0, base + 6);
    repeat (500) @(negedge clk);
    #1;
    chk("dut0 held during tx_done hold-off", sent[0] - base, 6);
    wait_sent(0, base + 8);
    spur_next[0] = 1'b1;
    wait_fd(0, f + 1);
    chk("dut0 frame length after reset", sent[0] - base, 2099);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
